m_ucode_loader: RTL and testbench
=================================

M_UCODE_LOADER -- requirements
Module: m_ucode_loader

Interface
REQ-001 Parameter NWORDS, default 256: number of 48-bit microcode words written per load; legal range 1..256.
REQ-002 Parameter BYTES_PER_WORD, default 6: bytes assembled per word; fixed at 6.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 nreset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a load.
REQ-006 din  input  8  incoming byte stream.
REQ-007 din_valid  input  1  din holds a valid byte.
REQ-008 din_ready  output  1  loader accepts din this cycle.
REQ-009 we  output  1  microcode EBR write strobe.
REQ-010 wadr  output  8  microcode EBR write address; drives the same index space as minx.
REQ-011 wdata  output  48  microcode word; bit mapping is identical to the control-store word d[47:0].
REQ-012 busy  output  1  a load is in progress.
REQ-013 done  output  1  the last load completed successfully; sticky.
REQ-014 err  output  1  the last load failed its check; sticky.

Function
REQ-015 The states SHALL be IDLE, COLLECT, WRITE, CHECK, DONE and ERR.
REQ-016 A byte is accepted only on a cycle with din_valid=1 and din_ready=1.
REQ-017 din_ready SHALL be 1 only in COLLECT and CHECK.
REQ-018 start SHALL take effect in IDLE, DONE or ERR:
  - next state COLLECT
  - wadr=0, byte counter=0, checksum=0
  - done and err cleared
REQ-019 start SHALL be ignored in COLLECT, WRITE and CHECK.
REQ-020 Bytes SHALL be packed little-endian: byte k of a word goes to wdata[8k+7:8k], k=0..5.
REQ-021 Accepting the 6th byte SHALL move the state to WRITE; the byte counter wraps to 0.
REQ-022 WRITE SHALL last exactly one cycle with we=1, stable wadr and stable wdata.
  - Latency: we is high in the cycle after the 6th byte is accepted.
REQ-023 After WRITE:
  - if wadr=NWORDS-1: next state CHECK when the macro is defined, DONE otherwise
  - else wadr increments by 1 and the state returns to COLLECT
REQ-024 wadr SHALL never exceed NWORDS-1; the increment for NWORDS=256 never wraps during a load.
REQ-025 we SHALL be 0 in every state except WRITE.
REQ-026 busy SHALL be 1 in COLLECT, WRITE and CHECK, and 0 otherwise.
REQ-027 din_valid deasserting mid-word SHALL stall the load with no timeout; the partial word is kept.
REQ-028 In DONE or ERR, wadr and wdata SHALL hold their last values.

Reset
REQ-029 While nreset=0, regardless of clock:
  - state=IDLE
  - we=0, din_ready=0, busy=0, done=0, err=0
  - wadr=0, wdata=0, byte counter=0, checksum=0
REQ-030 Reset asserted mid-load SHALL abort the load immediately; no further we occurs.
REQ-031 Deassertion SHALL be synchronised by the surrounding reset logic; the block needs no internal synchroniser.

Configuration
REQ-032 Macro UCODE_LOADER_CHECKSUM_EN SHALL control the checksum feature.
REQ-033 With UCODE_LOADER_CHECKSUM_EN defined:
  - every accepted data byte is added into an 8-bit checksum, mod 256
  - CHECK accepts one extra byte
  - if (checksum + byte) mod 256 = 0 the next state is DONE with done=1; otherwise ERR with err=1
REQ-034 Without UCODE_LOADER_CHECKSUM_EN:
  - no CHECK state and no checksum register
  - the last WRITE goes directly to DONE with done=1
  - err is tied to 0

Structure
REQ-035 Shared package m_ucode_pkg SHALL hold:
  - the state encoding
  - UCODE_W=48
  - UCODE_ADR_W=8
  - BYTES_PER_WORD=6
REQ-036 The checksum accumulator SHALL be the sub-module m_bytesum, with clear, add-enable, byte in and sum out.
  - It is instantiated only when UCODE_LOADER_CHECKSUM_EN is defined.

Verification
REQ-037 NWORDS=2, bytes 01..0C with din_valid held high -> we twice: wadr=0 with wdata=0x060504030201, then wadr=1 with wdata=0x0C0B0A090807; done=1.
REQ-038 Checksum build, NWORDS=1, bytes 01..06 then check byte 0xEB -> done=1, err=0; repeated with check byte 0xEC -> err=1, done=0.
REQ-039 din_valid toggled 1/0 every cycle over one word -> the word is still packed correctly; we occurs only once.
REQ-040 nreset pulsed low after 3 bytes of word 5 -> all outputs return to reset values at once; a new start reloads from wadr=0.
REQ-041 start pulsed during COLLECT -> no effect on wadr or the byte counter; start pulsed in DONE -> done clears and the load restarts.
REQ-042 NWORDS=256 full load -> the last we has wadr=0xFF; wadr never wraps to 0 during the load.

Source files
------------

// File: rtl/m_ucode_pkg.sv
// ============================================================================
// Module   : m_ucode_pkg
// Purpose  : Shared widths and state encoding for the microcode loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package m_ucode_pkg;

  localparam int UCODE_W        = 48;
  localparam int UCODE_ADR_W    = 8;
  localparam int BYTES_PER_WORD = 6;
  localparam int BCNT_W         = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_CHECK   = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/m_bytesum.sv
// ============================================================================
// Module   : m_bytesum
// Purpose  : 8-bit modulo-256 byte accumulator with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_bytesum (
  input  logic       clk,
  input  logic       nreset,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  // Clear wins over add so a restart never folds in a stale byte.
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = 8'd0;
    end else if (add_i) begin
      sum_d = sum_q + byte_i;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sum_q <= 8'd0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

`default_nettype wire

// File: rtl/m_ucode_loader.sv
// ============================================================================
// Module   : m_ucode_loader
// Purpose  : Packs a byte stream into 48-bit words and writes them to the
//            microcode EBR. Optional trailing checksum byte when the macro
//            UCODE_LOADER_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_ucode_loader #(
  parameter int NWORDS         = 256,
  parameter int BYTES_PER_WORD = 6
) (
  input  logic                               clk,
  input  logic                               nreset,
  input  logic                               start,
  input  logic [7:0]                         din,
  input  logic                               din_valid,
  output logic                               din_ready,
  output logic                               we,
  output logic [m_ucode_pkg::UCODE_ADR_W-1:0] wadr,
  output logic [m_ucode_pkg::UCODE_W-1:0]     wdata,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  import m_ucode_pkg::*;

  localparam logic [UCODE_ADR_W-1:0] c_LAST_ADR  = UCODE_ADR_W'(NWORDS - 1);
  localparam logic [BCNT_W-1:0]      c_LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

  state_t                 state_q, state_d;
  logic [UCODE_ADR_W-1:0] wadr_q,  wadr_d;
  logic [UCODE_W-1:0]     wdata_q, wdata_d;
  logic [BCNT_W-1:0]      bcnt_q,  bcnt_d;

`ifdef UCODE_LOADER_CHECKSUM_EN
  logic       sum_clr;
  logic       sum_add;
  logic [7:0] sum_q;
  logic [7:0] chk_total;

  assign chk_total = sum_q + din;

  m_bytesum u_bytesum (
    .clk    (clk),
    .nreset (nreset),
    .clr_i  (sum_clr),
    .add_i  (sum_add),
    .byte_i (din),
    .sum_o  (sum_q)
  );
`endif

  always_comb begin
    state_d = state_q;
    wadr_d  = wadr_q;
    wdata_d = wdata_q;
    bcnt_d  = bcnt_q;
`ifdef UCODE_LOADER_CHECKSUM_EN
    sum_clr = 1'b0;
    sum_add = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_COLLECT;
          wadr_d  = '0;
          bcnt_d  = '0;
`ifdef UCODE_LOADER_CHECKSUM_EN
          sum_clr = 1'b1;
`endif
        end
      end
      S_COLLECT: begin
        if (din_valid) begin
          // Little-endian: byte k of the word lands in bits [8k+7:8k].
          wdata_d[{bcnt_q, 3'b000} +: 8] = din;
`ifdef UCODE_LOADER_CHECKSUM_EN
          sum_add = 1'b1;
`endif
          if (bcnt_q == c_LAST_BYTE) begin
            bcnt_d  = '0;
            state_d = S_WRITE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (wadr_q == c_LAST_ADR) begin
`ifdef UCODE_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          wadr_d  = wadr_q + 1'b1;
          state_d = S_COLLECT;
        end
      end
      S_CHECK: begin
`ifdef UCODE_LOADER_CHECKSUM_EN
        if (din_valid) begin
          state_d = (chk_total == 8'd0) ? S_DONE : S_ERR;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      wadr_q  <= '0;
      wdata_q <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wadr_q  <= wadr_d;
      wdata_q <= wdata_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign din_ready = (state_q == S_COLLECT) || (state_q == S_CHECK);
  assign we        = (state_q == S_WRITE);
  assign busy      = (state_q == S_COLLECT) || (state_q == S_WRITE) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign wadr      = wadr_q;
  assign wdata     = wdata_q;
`ifdef UCODE_LOADER_CHECKSUM_EN
  assign err       = (state_q == S_ERR);
`else
  assign err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_m_ucode_loader.sv
// ============================================================================
// Module   : tb_m_ucode_loader
// Purpose  : Scoreboard bench for m_ucode_loader; honours UCODE_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m_ucode_loader;

  localparam int NW = 256;

  typedef struct {
    logic [7:0]  adr;
    logic [47:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        nreset;
  logic        start;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        we;
  logic [7:0]  wadr;
  logic [47:0] wdata;
  logic        busy;
  logic        done;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  wr_t         sb[$];
  wr_t         mon_e;
  logic [7:0]  model_sum;
  logic [7:0]  chk_byte;

  always #5 clk = ~clk;

  m_ucode_loader #(.NWORDS(NW), .BYTES_PER_WORD(6)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .we        (we),
    .wadr      (wadr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int w, input int k);
    return 8'((6 * w + k + 1) & 255);
  endfunction

  function automatic logic [47:0] word_of(input int w);
    logic [47:0] d;
    d = '0;
    for (int k = 0; k < 6; k++) d[8*k +: 8] = byte_of(w, k);
    return d;
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (nreset === 1'b1 && we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: wadr=%0h wdata=%0h, no write expected", wadr, wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("write_adr", 64'(wadr), 64'(mon_e.adr));
        chk("write_data", 64'(wdata), 64'(mon_e.data));
      end
    end
  end

  // Presents one byte from a negedge and returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    din       = b;
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL din_ready_timeout: got din_ready=%b, expected 1 within 100 cycles", din_ready);
    end
    @(negedge clk);
    din_valid = 1'b0;
    model_sum = model_sum + b;
    if (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_words(input int first, input int count, input int gap_word, input int start_word);
    for (int w = first; w < first + count; w++) begin
      sb.push_back('{adr: 8'(w), data: word_of(w)});
      for (int k = 0; k < 6; k++) begin
        if (w == start_word && k == 3) pulse_start();
        send_byte(byte_of(w, k), w == gap_word);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy=%b, expected 0 within 50 cycles", name, busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_done"},  64'(done),      64'd0);
    chk({tag, "_err"},   64'(err),       64'd0);
    chk({tag, "_we"},    64'(we),        64'd0);
    chk({tag, "_ready"}, 64'(din_ready), 64'd0);
    chk({tag, "_wadr"},  64'(wadr),      64'd0);
    chk({tag, "_wdata"}, 64'(wdata),     64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nreset    = 1'b0;
    start     = 1'b0;
    din       = 8'd0;
    din_valid = 1'b0;
    model_sum = 8'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    nreset = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Full load: word 2 with din_valid toggling, start pulsed mid-word 3.
    model_sum = 8'd0;
    pulse_start();
    chk("start_busy",  64'(busy),      64'd1);
    chk("start_ready", 64'(din_ready), 64'd1);
    load_words(0, NW, 2, 3);
`ifdef UCODE_LOADER_CHECKSUM_EN
    chk_byte = 8'd0 - model_sum;
    send_byte(chk_byte, 1'b0);
`endif
    wait_idle("load1");
    chk("load1_done",  64'(done),      64'd1);
    chk("load1_err",   64'(err),       64'd0);
    chk("load1_ready", 64'(din_ready), 64'd0);
    chk("load1_we",    64'(we),        64'd0);
    chk("load1_wadr_hold",  64'(wadr),  64'hFF);
    chk("load1_wdata_hold", 64'(wdata), 64'(word_of(NW - 1)));
    chk("load1_sb_empty", 64'(sb.size()), 64'd0);

    // Restart from DONE, then abort with reset after 3 bytes of word 5.
    model_sum = 8'd0;
    pulse_start();
    chk("restart_done", 64'(done), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    load_words(0, 5, -1, -1);
    for (int k = 0; k < 3; k++) send_byte(byte_of(5, k), 1'b0);
    chk("midload_wadr", 64'(wadr), 64'd5);
    nreset = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    chk("abort_sb_empty", 64'(sb.size()), 64'd0);
    nreset = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", 64'(busy), 64'd0);

    // Fresh load from address 0; checksum build gets a wrong check byte.
    model_sum = 8'd0;
    pulse_start();
    load_words(0, NW, -1, -1);
`ifdef UCODE_LOADER_CHECKSUM_EN
    chk_byte = (8'd0 - model_sum) + 8'd1;
    send_byte(chk_byte, 1'b0);
    wait_idle("load2");
    chk("load2_err",  64'(err),  64'd1);
    chk("load2_done", 64'(done), 64'd0);
`else
    wait_idle("load2");
    chk("load2_done", 64'(done), 64'd1);
    chk("load2_err",  64'(err),  64'd0);
`endif
    repeat (3) @(negedge clk);
    chk("load2_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
